// File: rtl/seq_counter_ctrl_if.sv
// Command/status bundle between the CPU control logic (master) and the
// control-step sequence counter (slave); instr_cnt exists only with SC_INSTR_CNT_EN.
interface seq_counter_ctrl_if #(
  parameter int SC_W = 3
);
  logic            sc_inc;
  logic            sc_clr;
  logic            sc_load;
  logic [SC_W-1:0] sc_load_val;
  logic            halt_req;
  logic            resume;
  logic [SC_W-1:0] sc_out;
  logic            sc_wrap;
  logic            instr_start;
  logic            halted;
`ifdef SC_INSTR_CNT_EN
  logic [15:0]     instr_cnt;
`endif

  modport master (
`ifdef SC_INSTR_CNT_EN
    input  instr_cnt,
`endif
    output sc_inc, sc_clr, sc_load, sc_load_val, halt_req, resume,
    input  sc_out, sc_wrap, instr_start, halted
  );

  modport slave (
`ifdef SC_INSTR_CNT_EN
    output instr_cnt,
`endif
    input  sc_inc, sc_clr, sc_load, sc_load_val, halt_req, resume,
    output sc_out, sc_wrap, instr_start, halted
  );
endinterface

// File: rtl/seq_counter_ctrl.sv
// Control-step sequence counter (T0..MAX_T) with RUN/HALT FSM; optional instr_cnt via SC_INSTR_CNT_EN.
// Latency: 1 clock from command to registered sc_out/sc_wrap/instr_start.
// Backpressure: none; lower-priority commands in the same cycle are dropped, never queued.
module seq_counter_ctrl #(
  parameter int SC_W  = 3,
  parameter int MAX_T = 7
) (
  input logic               clk,
  input logic               rst,
  seq_counter_ctrl_if.slave sc_if
);

  localparam logic [0:0]      ST_RUN  = 1'b0;
  localparam logic [0:0]      ST_HALT = 1'b1;
  localparam logic [SC_W-1:0] MAX_V   = SC_W'(MAX_T);
  localparam logic [SC_W-1:0] ONE_V   = SC_W'(1);

  logic [0:0]      state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            wrap_q, wrap_d;
  logic            start_q, start_d;
  logic [SC_W-1:0] load_clamped;

  assign load_clamped = (sc_if.sc_load_val > MAX_V) ? MAX_V : sc_if.sc_load_val;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    wrap_d  = 1'b0;
    start_d = 1'b0;
    if (state_q == ST_HALT) begin
      // Step commands are ignored while frozen; only resume (without halt_req) leaves.
      sc_d = '0;
      if (sc_if.resume && !sc_if.halt_req) begin
        state_d = ST_RUN;
        start_d = 1'b1;
      end
    end else if (sc_if.halt_req) begin
      state_d = ST_HALT;
      sc_d    = '0;
    end else if (sc_if.sc_clr) begin
      sc_d    = '0;
      start_d = 1'b1;
    end else if (sc_if.sc_load) begin
      sc_d    = load_clamped;
      start_d = (load_clamped == '0);
    end else if (sc_if.sc_inc) begin
      if (sc_q >= MAX_V) begin
        sc_d    = '0;
        wrap_d  = 1'b1;
        start_d = 1'b1;
      end else begin
        sc_d = sc_q + ONE_V;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      sc_q    <= '0;
      wrap_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      wrap_q  <= wrap_d;
      start_q <= start_d;
    end
  end

  assign sc_if.sc_out      = sc_q;
  assign sc_if.sc_wrap     = wrap_q;
  assign sc_if.instr_start = start_q;
  assign sc_if.halted      = (state_q == ST_HALT);

`ifdef SC_INSTR_CNT_EN
  logic [15:0] cnt_q;

  // Counts on the same edge that registers instr_start, so it stays aligned with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_d) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sc_if.instr_cnt = cnt_q;
`endif

  a_sc_range : assert property (@(posedge clk) disable iff (rst) sc_q <= MAX_V);
  a_wrap_zero : assert property (@(posedge clk) disable iff (rst) wrap_q |-> (start_q && sc_q == '0));

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Drives a MAX_T=7 and a MAX_T=4 counter with identical stimulus and compares both
// against an integer reference model every cycle.
module tb_seq_counter_ctrl;

  localparam int SC_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_inc = 1'b0, t_clr = 1'b0, t_load = 1'b0, t_hreq = 1'b0, t_res = 1'b0;
  logic [SC_W-1:0] t_lval = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_counter_ctrl_if #(.SC_W(SC_W)) if7 ();
  seq_counter_ctrl_if #(.SC_W(SC_W)) if4 ();

  assign if7.sc_inc = t_inc;   assign if4.sc_inc = t_inc;
  assign if7.sc_clr = t_clr;   assign if4.sc_clr = t_clr;
  assign if7.sc_load = t_load; assign if4.sc_load = t_load;
  assign if7.sc_load_val = t_lval; assign if4.sc_load_val = t_lval;
  assign if7.halt_req = t_hreq; assign if4.halt_req = t_hreq;
  assign if7.resume = t_res;   assign if4.resume = t_res;

  seq_counter_ctrl #(.SC_W(SC_W), .MAX_T(7)) u_dut7 (.clk(clk), .rst(rst), .sc_if(if7));
  seq_counter_ctrl #(.SC_W(SC_W), .MAX_T(4)) u_dut4 (.clk(clk), .rst(rst), .sc_if(if4));

  // Reference model: index 0 is the MAX_T=7 build, index 1 the MAX_T=4 build.
  int mmax[2] = '{7, 4};
  int m_sc[2];
  bit m_halt[2], m_wrap[2], m_start[2];
  int m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int v;
      m_wrap[i]  = 0;
      m_start[i] = 0;
      if (rst) begin
        m_sc[i] = 0; m_halt[i] = 0; m_cnt[i] = 0;
      end else if (m_halt[i]) begin
        if (t_res && !t_hreq) begin
          m_halt[i] = 0; m_start[i] = 1;
        end
      end else if (t_hreq) begin
        m_halt[i] = 1; m_sc[i] = 0;
      end else if (t_clr) begin
        m_sc[i] = 0; m_start[i] = 1;
      end else if (t_load) begin
        v = int'(t_lval);
        if (v > mmax[i]) v = mmax[i];
        m_sc[i] = v;
        m_start[i] = (v == 0);
      end else if (t_inc) begin
        m_sc[i] = (m_sc[i] + 1) % (mmax[i] + 1);
        if (m_sc[i] == 0) begin
          m_wrap[i] = 1; m_start[i] = 1;
        end
      end
      if (!rst && m_start[i]) m_cnt[i] = (m_cnt[i] + 1) % 65536;
    end
  endtask

  task automatic check_all();
    chk("d7.sc_out", 32'(if7.sc_out), 32'(m_sc[0]));
    chk("d7.sc_wrap", 32'(if7.sc_wrap), 32'(m_wrap[0]));
    chk("d7.instr_start", 32'(if7.instr_start), 32'(m_start[0]));
    chk("d7.halted", 32'(if7.halted), 32'(m_halt[0]));
    chk("d4.sc_out", 32'(if4.sc_out), 32'(m_sc[1]));
    chk("d4.sc_wrap", 32'(if4.sc_wrap), 32'(m_wrap[1]));
    chk("d4.instr_start", 32'(if4.instr_start), 32'(m_start[1]));
    chk("d4.halted", 32'(if4.halted), 32'(m_halt[1]));
`ifdef SC_INSTR_CNT_EN
    chk("d7.instr_cnt", 32'(if7.instr_cnt), 32'(m_cnt[0]));
    chk("d4.instr_cnt", 32'(if4.instr_cnt), 32'(m_cnt[1]));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit inc, input bit clr, input bit ld,
                       input int lv, input bit hreq, input bit res);
    rst = r; t_inc = inc; t_clr = clr; t_load = ld;
    t_lval = SC_W'(lv); t_hreq = hreq; t_res = res;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_sc[i] = 0; m_halt[i] = 0; m_wrap[i] = 0; m_start[i] = 0; m_cnt[i] = 0;
    end

    // Reset for two cycles, then idle.
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset.sc_out", 32'(if7.sc_out), 32'd0);
    chk("reset.halted", 32'(if7.halted), 32'd0);

    // Full increment sweep: wrap on the eighth step (fifth for MAX_T=4).
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      chk("sweep.sc_out", 32'(if7.sc_out), 32'(k % 8));
      chk("sweep.wrap", 32'(if7.sc_wrap), 32'(k == 8));
    end

    // Clear beats increment at step 3.
    repeat (3) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    chk("clr.sc_out", 32'(if7.sc_out), 32'd0);
    chk("clr.instr_start", 32'(if7.instr_start), 32'd1);
    chk("clr.sc_wrap", 32'(if7.sc_wrap), 32'd0);

    // Loads, including clamp on the MAX_T=4 build and a load of 0.
    drive(0, 0, 0, 1, 5, 0, 0);
    chk("load5.d7", 32'(if7.sc_out), 32'd5);
    chk("load5.d4", 32'(if4.sc_out), 32'd4);
    drive(0, 1, 0, 1, 6, 0, 0);
    chk("load6.d4", 32'(if4.sc_out), 32'd4);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("load0.instr_start", 32'(if7.instr_start), 32'd1);

    // Halt at step 2, ignore increments, then resume.
    drive(0, 0, 0, 1, 2, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    chk("halt.sc_out", 32'(if7.sc_out), 32'd0);
    chk("halt.halted", 32'(if7.halted), 32'd1);
    repeat (3) begin
      drive(0, 1, 1, 1, 3, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("halt_resume_blocked", 32'(if7.halted), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("resume.halted", 32'(if7.halted), 32'd0);
    chk("resume.instr_start", 32'(if7.instr_start), 32'd1);

    // Reset mid-instruction: no instr_start on the reset edge.
    repeat (3) drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    chk("midrst.sc_out", 32'(if7.sc_out), 32'd0);
    chk("midrst.instr_start", 32'(if7.instr_start), 32'd0);

    // Randomized traffic with occasional halts, resumes and resets.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 12,
            int'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 30);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
